// File: rtl/idct8_stream.sv
// idct8_stream: streaming 8-point 1-D inverse DCT.
//
// Ports:
//   clk          - clock, all state updates on rising edge
//   rst          - asynchronous active-high reset
//   enable       - data_in accepted on a rising edge where enable=1
//   block_start  - with enable, forces data_in to be taken as X[0]
//   data_in      - signed coefficient X[k], k = 0..7 in order
//   idct_out     - signed reconstructed sample x[n]
//   out_valid    - idct_out holds a valid sample this cycle
//   out_index    - n of the sample on idct_out
//   out_last     - high with out_valid when n = 7
//
// Generator states:
//   state  | meaning
//   S_IDLE | no block pending, outputs hold value, out_valid/out_last low
//   S_RUN  | emitting x[n] from the hold buffer, one sample per edge
module idct8_stream #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     block_start,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [DATA_W-1:0] idct_out,
  output logic                     out_valid,
  output logic [2:0]               out_index,
  output logic                     out_last
);

  localparam int ACC_W = 2*DATA_W + 3;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< (FRAC_BITS-1);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(1 << (DATA_W-1));

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // W[n][k] via cosine symmetry on m = (2n+1)k mod 32.
  // Magnitudes are 0.5*cos(m*pi/16) and sqrt(1/8) scaled by 2^14.
  function automatic logic signed [DATA_W-1:0] coef(input logic [2:0] n,
                                                     input logic [2:0] k);
    logic [4:0]               m;
    logic                     neg;
    logic signed [DATA_W-1:0] mag;
    m   = 5'({n, 1'b1}) * 5'(k);
    neg = 1'b0;
    if (m > 5'd16) m = 5'd0 - m;
    if (m > 5'd8) begin
      neg = 1'b1;
      m   = 5'd16 - m;
    end
    case (m)
      5'd0:    mag = DATA_W'(8192);
      5'd1:    mag = DATA_W'(8035);
      5'd2:    mag = DATA_W'(7568);
      5'd3:    mag = DATA_W'(6811);
      5'd4:    mag = DATA_W'(5793);
      5'd5:    mag = DATA_W'(4551);
      5'd6:    mag = DATA_W'(3135);
      5'd7:    mag = DATA_W'(1598);
      default: mag = '0;
    endcase
    if (k == 3'd0) coef = DATA_W'(5793);
    else           coef = neg ? -mag : mag;
  endfunction

  logic [2:0]               kin_q, kin_d;
  logic signed [DATA_W-1:0] cap_q  [8];
  logic signed [DATA_W-1:0] cap_d  [8];
  logic signed [DATA_W-1:0] hold_q [8];
  logic signed [DATA_W-1:0] hold_d [8];
  logic                     hold_load;

  state_t                   state_q, state_d;
  logic [2:0]               n_q, n_d;
  logic signed [DATA_W-1:0] idct_out_q, idct_out_d;
  logic                     out_valid_q, out_valid_d;
  logic [2:0]               out_index_q, out_index_d;
  logic                     out_last_q, out_last_d;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] sample;

  // x[n_q] from the current hold buffer (the old block on a reload edge)
  always_comb begin
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      acc = acc + ACC_W'(hold_q[k]) * ACC_W'(coef(n_q, 3'(k)));
    end
    shifted = (acc + RND) >>> FRAC_BITS;
    if (shifted > MAXV)      sample = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < MINV) sample = {1'b1, {(DATA_W-1){1'b0}}};
    else                     sample = shifted[DATA_W-1:0];
  end

  always_comb begin
    kin_d     = kin_q;
    cap_d     = cap_q;
    hold_d    = hold_q;
    hold_load = 1'b0;
    if (enable) begin
      if (block_start) begin
        cap_d[0] = data_in;
        kin_d    = 3'd1;
      end else begin
        cap_d[kin_q] = data_in;
        kin_d        = kin_q + 3'd1;
        if (kin_q == 3'd7) begin
          hold_load = 1'b1;
          hold_d    = cap_d;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    idct_out_d  = idct_out_q;
    out_valid_d = 1'b0;
    out_index_d = out_index_q;
    out_last_d  = 1'b0;
    if (state_q == S_RUN) begin
      idct_out_d  = sample;
      out_valid_d = 1'b1;
      out_index_d = n_q;
      out_last_d  = (n_q == 3'd7);
      n_d         = n_q + 3'd1;
      if (n_q == 3'd7) state_d = S_IDLE;
    end
    // a new block restarts at n=0, overriding the return to idle after n=7
    if (hold_load) begin
      state_d = S_RUN;
      n_d     = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kin_q <= '0;
      for (int i = 0; i < 8; i++) begin
        cap_q[i]  <= '0;
        hold_q[i] <= '0;
      end
      state_q     <= S_IDLE;
      n_q         <= '0;
      idct_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      kin_q       <= kin_d;
      cap_q       <= cap_d;
      hold_q      <= hold_d;
      state_q     <= state_d;
      n_q         <= n_d;
      idct_out_q  <= idct_out_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

  assign idct_out  = idct_out_q;
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;

endmodule

// File: doc/idct8_stream.md
Name: idct8_stream

Overview:
- Streaming 8-point 1-D inverse DCT; the decode-side counterpart of dct_top.
- Accepts serial signed DCT coefficients on the same clk/rst/enable/data_in style interface.
- Regenerates 8 spatial samples per block, one per cycle, with a valid/index/last sideband.
- Input capture is double-buffered against output generation, so back-to-back blocks stream continuously.

Parameters:
DATA_W, 16, width of signed input coefficients and output samples
FRAC_BITS, 14, fractional bits of the internal cosine ROM (coefficients signed, DATA_W wide)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  data_in is accepted on a rising edge where enable=1
block_start  input  1  qualified by enable; forces the current data_in to be taken as X[0]
data_in  input  DATA_W  signed coefficient X[k], k = 0..7 in order
idct_out  output  DATA_W  signed reconstructed sample x[n]
out_valid  output  1  idct_out holds a valid sample this cycle
out_index  output  3  n of the sample on idct_out
out_last  output  1  high with out_valid when n = 7

Behaviour:
- Reset: async on rst high; all counters, buffers and outputs clear. idct_out=0, out_valid=0, out_index=0, out_last=0, generator idle.
- Transform: x[n] = sum over k=0..7 of W[n][k]*X[k].
  - W[n][k] = round(a_k * cos((2n+1)k*pi/16) * 2^FRAC_BITS).
  - a_0 = sqrt(1/8); a_k = 1/2 for k>0.
  - ROM values at defaults: W[n][0] = 5793 for all n; W[0][1] = 8035; W[7][1] = -8035.
- Arithmetic:
  - Full-precision signed products, summed in at least 2*DATA_W+3 bits.
  - result = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift, i.e. floor after half-up bias).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; no wrap.
- Input side: 3-bit capture counter kin.
  - Each accepted sample is written to capture buffer slot kin, then kin increments.
  - enable=0: no write, kin holds; gaps of any length are allowed.
  - block_start=1 with enable=1: sample written to slot 0 and kin becomes 1, discarding any partial block.
  - The accept that writes slot 7, edge E0, copies the 8 coefficients (the new one included) into the hold buffer; kin wraps to 0 and the generator starts at n=0.
- Output side: generator states IDLE and RUN, with a 3-bit counter n.
  - On each edge in RUN, the output register loads x[n] from the hold buffer: out_valid=1, out_index=n, out_last=(n==7), then n increments.
  - After loading n=7, the generator returns to IDLE unless a new block was loaded on that same edge.
  - Timing: x[0] is registered at E0+1, x[7] at E0+8, i.e. one-cycle latency from the last coefficient.
  - In IDLE, out_valid=0, out_last=0, and idct_out/out_index hold their last values.
- Back-to-back blocks: the earliest next hold-load coincides with the edge that loads x[7] of the current block.
  - That edge emits the old x[7] (computed from the old hold contents) and loads the new hold buffer.
  - The next edge emits the new x[0], so out_valid stays continuously high.
  - A hold-load can never occur earlier than that; no overrun case exists.
- Generator independence: the generator does not depend on enable. Output drains even when input stops.
- Reset mid-block: partial capture discarded and an in-flight output burst aborted. The first complete block after reset produces output normally.

Test Plan:
- DC: reset, then X = {800,0,0,0,0,0,0,0} with enable held high -> out_valid for 8 consecutive cycles starting one cycle after X[7]; all x[n] = 283; out_index 0..7; out_last only on n=7.
- Odd basis: X = {0,1000,0,0,0,0,0,0} -> x[0] = 490, x[7] = -490; sign pattern of outputs +,+,+,+,-,-,-,-.
- Saturation: all X[k] = 32767 -> x[0] = 32767 (saturated, not wrapped); all X[k] = -32768 -> x[0] = -32768.
- Gaps and back-to-back: block A with enable toggling 1/0 each cycle, then block B then C fed with enable stuck at 1 -> A outputs correct despite gaps; B and C outputs contiguous with no out_valid drop between B x[7] and C x[0].
- Resync: feed 5 coefficients, then assert block_start with DC block {800,0,...} -> only one burst (all 283) is emitted; the 5 stale samples never appear.
- Reset mid-operation: assert rst during output n=3 -> out_valid=0 immediately (async); the next full block after release yields correct outputs with out_index starting at 0.
